// File: rtl/bus_copy_pkg.sv
// Shared types and widths for the bus copy engine and its optional watchdog.
package bus_copy_pkg;

  localparam int unsigned ADDR_W  = 19;
  localparam int unsigned COUNT_W = 16;
  localparam int unsigned DATA_W  = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/bus_copy_timeout.sv
// Clearable watchdog: expired asserts on the TIMEOUT_CYCLES-th consecutive enabled cycle.
// Instantiated by bus_copy_engine only when DMA_TIMEOUT_EN is defined.
module bus_copy_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CW-1:0] cnt;

  assign expired = enable && (cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && !expired) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/bus_copy_engine.sv
// Word-granular block-copy initiator: alternating single-word reads and writes.
// Optional watchdog abort enabled by defining DMA_TIMEOUT_EN.
module bus_copy_engine
  import bus_copy_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [ADDR_W-1:0]  src_addr,
  input  logic [ADDR_W-1:0]  dst_addr,
  input  logic [COUNT_W-1:0] count,
  output logic               busy,
  output logic               done,
  output logic               error,
  output logic [ADDR_W-1:0]  m_addr,
  input  logic [DATA_W-1:0]  m_data_in,
  output logic [DATA_W-1:0]  m_data_out,
  output logic               m_access,
  input  logic               m_ack,
  output logic               m_wr_en,
  output logic [1:0]         m_bytesel
);

  state_t             state;
  logic [ADDR_W-1:0]  src_ptr;
  logic [ADDR_W-1:0]  dst_ptr;
  logic [COUNT_W-1:0] remaining;
  logic [DATA_W-1:0]  hold;

  assign m_bytesel = 2'b11;

`ifdef DMA_TIMEOUT_EN
  logic expired;

  bus_copy_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (!m_access),
    .enable  (m_access && !m_ack),
    .expired (expired)
  );
`else
  assign error = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      src_ptr    <= '0;
      dst_ptr    <= '0;
      remaining  <= '0;
      hold       <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      m_addr     <= '0;
      m_data_out <= '0;
      m_access   <= 1'b0;
      m_wr_en    <= 1'b0;
`ifdef DMA_TIMEOUT_EN
      error      <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
`ifdef DMA_TIMEOUT_EN
            error <= 1'b0;
`endif
            if (count == '0) begin
              // Zero-length copy pulses done straight from IDLE; DONE then clears it.
              done  <= 1'b1;
              state <= DONE;
            end else begin
              src_ptr   <= src_addr;
              dst_ptr   <= dst_addr;
              remaining <= count;
              busy      <= 1'b1;
              m_access  <= 1'b1;
              m_wr_en   <= 1'b0;
              m_addr    <= src_addr;
              state     <= READ;
            end
          end
        end

        READ: begin
          if (!m_access) begin
            m_access <= 1'b1;
            m_wr_en  <= 1'b0;
            m_addr   <= src_ptr;
          end else if (m_ack) begin
            hold     <= m_data_in;
            src_ptr  <= src_ptr + 1'b1;
            m_access <= 1'b0;
            state    <= WRITE;
          end
`ifdef DMA_TIMEOUT_EN
          else if (expired) begin
            m_access <= 1'b0;
            error    <= 1'b1;
            state    <= DONE;
          end
`endif
        end

        WRITE: begin
          if (!m_access) begin
            m_access   <= 1'b1;
            m_wr_en    <= 1'b1;
            m_addr     <= dst_ptr;
            m_data_out <= hold;
          end else if (m_ack) begin
            dst_ptr   <= dst_ptr + 1'b1;
            remaining <= remaining - 1'b1;
            m_access  <= 1'b0;
            state     <= (remaining == COUNT_W'(1)) ? DONE : READ;
          end
`ifdef DMA_TIMEOUT_EN
          else if (expired) begin
            m_access <= 1'b0;
            error    <= 1'b1;
            state    <= DONE;
          end
`endif
        end

        DONE: begin
          done  <= ~done;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_copy_engine.sv
// Self-checking bench for bus_copy_engine: table-driven copies plus directed corner sequences.
module tb_bus_copy_engine;
  import bus_copy_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [18:0] src_addr, dst_addr;
  logic [15:0] count;
  logic        busy, done, error;
  logic [18:0] m_addr;
  logic [15:0] m_data_in, m_data_out;
  logic        m_access, m_ack, m_wr_en;
  logic [1:0]  m_bytesel;

  bus_copy_engine #(.TIMEOUT_CYCLES(16)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .src_addr   (src_addr),
    .dst_addr   (dst_addr),
    .count      (count),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .m_addr     (m_addr),
    .m_data_in  (m_data_in),
    .m_data_out (m_data_out),
    .m_access   (m_access),
    .m_ack      (m_ack),
    .m_wr_en    (m_wr_en),
    .m_bytesel  (m_bytesel)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [18:0] addr;
    logic [15:0] data;
  } txn_t;

  typedef struct {
    logic [18:0] src;
    logic [18:0] dst;
    logic [15:0] cnt;
    int          lat;
    logic [15:0] exp_first;
    logic [18:0] exp_last_rd;
    logic [18:0] exp_last_wr;
  } vec_t;

  txn_t txq[$];
  int   n_checks = 0, n_pass = 0;
  int   cyc = 0;
  int   lat_mode = 0, cur_lat = 0, wait_n = 0;
  int   last_ack_edge = 0, done_edge = 0, done_cnt = 0, acc_cycles = 0;
  logic busy_at_done = 1'b0, err_at_done = 1'b0;
  logic any_access = 1'b0, any_busy = 1'b0, reassert_pending = 1'b0;

  // Responder memory contents: address 0x00100 holds 16'hbeef, others offset from it.
  function automatic logic [15:0] rd_data(input logic [18:0] a);
    return 16'hbeef + (a[15:0] - 16'h0100);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic int next_lat();
    if (lat_mode >= 0) return lat_mode;
    if (lat_mode == -1) return int'($urandom_range(5, 0));
    return 1000000;
  endfunction

  task automatic set_lat(input int mode);
    lat_mode = mode;
    cur_lat  = next_lat();
    wait_n   = 0;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      done_edge    = cyc + 1;
      busy_at_done = busy;
      err_at_done  = error;
    end
    if (m_access) begin
      any_access = 1'b1;
      acc_cycles++;
    end
    if (busy) any_busy = 1'b1;
  end

  // Bus responder: acks after cur_lat waiting cycles, logs every completed transaction.
  initial begin
    m_ack = 1'b0;
    m_data_in = '0;
    forever begin
      @(negedge clk);
      if (reassert_pending) begin
        reassert_pending = 1'b0;
        if (busy && reset_n) check("reassert_a2", m_access, 1);
      end
      if (!reset_n) begin
        m_ack  = 1'b0;
        wait_n = 0;
      end else if (m_ack) begin
        m_ack = 1'b0;
        last_ack_edge = cyc;
        check("ack_gap", m_access, 0);
        reassert_pending = 1'b1;
      end else if (m_access) begin
        if (wait_n >= cur_lat) begin
          if (!m_wr_en) m_data_in = rd_data(m_addr);
          txq.push_back('{m_wr_en, m_addr, m_wr_en ? m_data_out : rd_data(m_addr)});
          check("bytesel", m_bytesel, 2'b11);
          m_ack   = 1'b1;
          wait_n  = 0;
          cur_lat = next_lat();
        end else begin
          wait_n++;
        end
      end else begin
        wait_n = 0;
      end
    end
  end

  task automatic do_start(input logic [18:0] s, input logic [18:0] d, input logic [15:0] c);
    @(negedge clk);
    start = 1'b1; src_addr = s; dst_addr = d; count = c;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    for (int i = 0; i < budget && done_cnt == 0; i++) @(negedge clk);
    check({tag, "_done_seen"}, done_cnt != 0, 1);
    repeat (3) @(negedge clk);
    check({tag, "_done_pulses"}, done_cnt, 1);
  endtask

  task automatic run_copy(input vec_t v, input string tag, input int inject_at);
    logic [18:0] ra, wa;
    int n;
    txq.delete();
    done_cnt = 0;
    set_lat(v.lat);
    do_start(v.src, v.dst, v.cnt);
    check({tag, "_busy_t1"}, busy, 1);
    check({tag, "_acc_t1"}, m_access, 1);
    check({tag, "_rd_t1"}, m_wr_en, 0);
    check({tag, "_addr_t1"}, m_addr, v.src);
    if (inject_at > 0) begin
      repeat (inject_at) @(negedge clk);
      do_start(19'h0, 19'h0, 16'd10);
    end
    wait_done(tag, int'(v.cnt) * 30 + 100);
    n = int'(v.cnt) * 2;
    check({tag, "_txn_count"}, txq.size(), n);
    if (txq.size() == n) begin
      ra = v.src;
      wa = v.dst;
      for (int i = 0; i < int'(v.cnt); i++) begin
        check({tag, "_rd_kind"}, txq[2*i].wr, 0);
        check({tag, "_rd_addr"}, txq[2*i].addr, ra);
        check({tag, "_wr_kind"}, txq[2*i+1].wr, 1);
        check({tag, "_wr_addr"}, txq[2*i+1].addr, wa);
        check({tag, "_wr_data"}, txq[2*i+1].data, rd_data(ra));
        ra = ra + 19'd1;
        wa = wa + 19'd1;
      end
      check({tag, "_first_data"}, txq[1].data, v.exp_first);
      check({tag, "_last_rd"}, txq[n-2].addr, v.exp_last_rd);
      check({tag, "_last_wr"}, txq[n-1].addr, v.exp_last_wr);
    end
    check({tag, "_done_after_ack"}, done_edge - last_ack_edge, 2);
    check({tag, "_busy_at_done"}, busy_at_done, 0);
  endtask

  vec_t vecs[4];
  vec_t extra;

  initial begin
    vecs[0] = '{19'h00100, 19'h00200, 16'd1, 3,  16'hbeef, 19'h00100, 19'h00200};
    vecs[1] = '{19'h00400, 19'h00800, 16'd8, -1, 16'hc1ef, 19'h00407, 19'h00807};
    vecs[2] = '{19'h7fffe, 19'h01000, 16'd4, 0,  16'hbded, 19'h00001, 19'h01003};
    vecs[3] = '{19'h00050, 19'h7ffff, 16'd3, 2,  16'hbe3f, 19'h00052, 19'h00001};

    reset_n = 1'b0; start = 1'b0; src_addr = '0; dst_addr = '0; count = '0;
    repeat (3) @(negedge clk);
    check("rst_access", m_access, 0);
    check("rst_wr_en", m_wr_en, 0);
    check("rst_addr", m_addr, 0);
    check("rst_data_out", m_data_out, 0);
    check("rst_bytesel", m_bytesel, 2'b11);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    reset_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 4; i++) run_copy(vecs[i], $sformatf("vec%0d", i), 0);

    // Zero-length copy: done pulses the cycle after start, no bus or busy activity.
    any_access = 1'b0; any_busy = 1'b0; done_cnt = 0; txq.delete();
    do_start(19'h00123, 19'h00456, 16'd0);
    check("zero_done_t1", done, 1);
    check("zero_busy_t1", busy, 0);
    @(negedge clk);
    check("zero_done_t2", done, 0);
    repeat (3) @(negedge clk);
    check("zero_no_access", any_access, 0);
    check("zero_no_busy", any_busy, 0);
    check("zero_done_pulses", done_cnt, 1);

    // Start while busy must be ignored; original 3-word copy completes.
    extra = '{19'h00600, 19'h00700, 16'd3, 1, 16'hc3ef, 19'h00602, 19'h00702};
    run_copy(extra, "busy_start", 3);
    any_access = 1'b0;
    repeat (10) @(negedge clk);
    check("busy_start_quiet", any_access, 0);

    // Asynchronous reset in the middle of an unacknowledged read.
    txq.delete(); done_cnt = 0;
    set_lat(-2);
    do_start(19'h00900, 19'h00a00, 16'd2);
    repeat (3) @(negedge clk);
    check("mid_rst_pre_access", m_access, 1);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_access_async", m_access, 0);
    check("mid_rst_busy_async", busy, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("mid_rst_state", 32'(dut.state), 32'(IDLE));
    check("mid_rst_access", m_access, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_no_txn", txq.size(), 0);
    extra = '{19'h00a00, 19'h00b00, 16'd2, 0, 16'hc7ef, 19'h00a01, 19'h00b01};
    run_copy(extra, "post_rst", 0);

`ifdef DMA_TIMEOUT_EN
    txq.delete(); done_cnt = 0; acc_cycles = 0;
    set_lat(-2);
    do_start(19'h01000, 19'h02000, 16'd2);
    wait_done("timeout", 60);
    check("timeout_err_at_done", err_at_done, 1);
    check("timeout_access_cycles", acc_cycles, 16);
    check("timeout_access_low", m_access, 0);
    check("timeout_error_held", error, 1);
    done_cnt = 0;
    set_lat(0);
    do_start(19'h00010, 19'h00020, 16'd1);
    check("timeout_error_cleared", error, 0);
    wait_done("timeout_recover", 100);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

endmodule
